stream_router_fifo: RTL and testbench
=====================================

Name: stream_router_fifo

Overview:
Parametrised successor to the combinational 1-to-4 router. Routes a valid/ready input stream to one of NUM_OUT output channels, or to all channels in broadcast mode. Each output channel has its own DEPTH-entry FIFO with valid/ready back-pressure. The block sits between a single producer and NUM_OUT independent consumers; words addressed to an out-of-range channel are dropped and counted.

Parameters:
DATA_WIDTH, 32, payload width in bits
NUM_OUT, 4, number of output channels (2..16)
DEPTH, 4, entries per output FIFO (power of 2, >=2)
ADDR_W, derived localparam = max(1, clog2(NUM_OUT)), width of addr

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
din  in  DATA_WIDTH  input payload
din_valid  in  1  input word present
din_ready  out  1  block can accept the word this cycle
addr  in  ADDR_W  destination channel, sampled with din_valid
bcast  in  1  1 = write word to every channel (addr ignored)
dout  out  NUM_OUT*DATA_WIDTH  flattened; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
dout_valid  out  NUM_OUT  channel i head word valid
dout_ready  in  NUM_OUT  consumer i takes head word
drop_count  out  16  saturating count of dropped out-of-range words

Behaviour:
- Reset (async, active-high): all FIFOs empty, write/read pointers 0, dout_valid = 0, dout = 0, drop_count = 0. Asserting reset mid-transfer discards all buffered words; nothing is popped or accepted in that cycle.
- Accept: transfer occurs when din_valid && din_ready on a rising edge.
- din_ready (combinational from addr, bcast, FIFO full flags, never from din_valid):
  - bcast=1: 1 only if no FIFO is full.
  - bcast=0, addr < NUM_OUT: !full[addr].
  - bcast=0, addr >= NUM_OUT: 1 (the word is consumed and dropped).
- Write: accepted word is pushed into FIFO[addr], or into all FIFOs when bcast=1. Broadcast is atomic: all channels or none.
- Drop: accepted word with bcast=0 and addr >= NUM_OUT is written nowhere. drop_count increments by 1 and saturates at 16'hFFFF.
- Output i: dout_valid[i] = !empty[i]. The dout slice shows the FIFO head; slice is 0 when empty, consistent with the zero-when-unselected legacy behaviour. Pop happens when dout_valid[i] && dout_ready[i].
- Latency: a word accepted at edge N is visible on its dout_valid from edge N onward, i.e. one cycle after presentation. There is no combinational din->dout path.
- Simultaneous push and pop on the same non-empty, non-full channel: both occur and occupancy is unchanged.
- Full FIFO with pop in the same cycle: din_ready is still 0 (no same-cycle pass-through); the push is accepted the next cycle.
- Pop on an empty channel is ignored.
- Occupancy counters are 0..DEPTH (clog2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Channels are independent: stalling one consumer never blocks traffic addressed to another channel. It does block broadcasts.
- Order is preserved per channel. No ordering is guaranteed across channels.
- dout_ready is ignored while dout_valid is 0. din/addr/bcast are don't-care while din_valid=0.

Test Plan:
- Reset then single route: din=32'hA5A5_0001, addr=2, valid 1 cycle, all dout_ready=0 -> next cycle dout_valid=4'b0100, slice 2 = 32'hA5A5_0001, other slices 0, drop_count=0.
- Fill/back-pressure: 4 words 1..4 to addr=1 with dout_ready=0 -> din_ready=0 on 5th attempt to addr=1. A concurrent word to addr=0 is accepted. Raising dout_ready[1] drains 1,2,3,4 in order over 4 cycles.
- Broadcast: fill channel 3 to 4 entries, then bcast=1, din=32'hBEEF -> din_ready=0 and no channel written. After one pop on channel 3, the broadcast is accepted and all 4 channels show 32'hBEEF as their newest entry.
- Simultaneous push/pop: channel 0 holds 2 words, push 32'h7 and pop in the same cycle -> occupancy stays 2, output order intact.
- Out-of-range drop (NUM_OUT=3): addr=3, din_valid=1 for 3 cycles -> din_ready=1, no dout_valid change, drop_count=3. Force 65537 drops -> drop_count=16'hFFFF.
- Reset mid-operation: channels hold 3,1,0,2 words, assert reset asynchronously between edges -> dout_valid=0, dout=0, drop_count=0 immediately. After release, a new word to addr=0 appears alone.

Source files
------------

// File: rtl/stream_router_fifo_if.sv
// stream_router_fifo_if: producer-side input stream plus per-channel output streams
interface stream_router_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT = 4,
  parameter int ADDR_W = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1
);
  logic [DATA_WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic [ADDR_W-1:0] addr;
  logic bcast;
  logic [NUM_OUT*DATA_WIDTH-1:0] dout;
  logic [NUM_OUT-1:0] dout_valid;
  logic [NUM_OUT-1:0] dout_ready;
  modport slave (input din, din_valid, addr, bcast, dout_ready, output din_ready, dout, dout_valid);
  modport master (output din, din_valid, addr, bcast, dout_ready, input din_ready, dout, dout_valid);
endinterface

// File: rtl/stream_router_fifo.sv
// stream_router_fifo: routes a valid/ready stream into per-channel FIFOs, with broadcast and out-of-range drop counting
module stream_router_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT = 4,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  stream_router_fifo_if.slave io,
  output logic [15:0] drop_count
);
  localparam int ADDR_W = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  localparam int PW = $clog2(DEPTH);
  logic [NUM_OUT-1:0] sel, full, empty, push, pop;
  logic accept;
  // an address matching no channel selects nothing, so it is always ready and gets dropped
  assign io.din_ready = io.bcast ? ~|full : ~|(sel & full);
  assign accept = io.din_valid & io.din_ready;
  assign push = {NUM_OUT{accept}} & (io.bcast ? {NUM_OUT{1'b1}} : sel);
  assign pop = io.dout_ready & ~empty;
  assign io.dout_valid = ~empty;
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    assign sel[i] = io.addr == ADDR_W'(i);
    assign full[i] = cnt == (PW+1)'(DEPTH);
    assign empty[i] = cnt == '0;
    assign io.dout[i*DATA_WIDTH +: DATA_WIDTH] = empty[i] ? '0 : mem[rp];
    always_ff @(posedge clk)
      if (push[i]) mem[wp] <= io.din;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push[i]) wp <= wp + 1'b1;
        if (pop[i]) rp <= rp + 1'b1;
        cnt <= cnt + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) drop_count <= '0;
    else if (accept && !io.bcast && !(|sel) && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
endmodule

// File: tb/tb_stream_router_fifo.sv
// tb_stream_router_fifo: directed vector table plus hand sequences for drop saturation and async reset
module tb_stream_router_fifo;
  logic clk = 0;
  logic reset = 1;
  logic [15:0] drop4, drop3;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  stream_router_fifo_if #(.DATA_WIDTH(32), .NUM_OUT(4)) io4 ();
  stream_router_fifo_if #(.DATA_WIDTH(32), .NUM_OUT(3)) io3 ();
  stream_router_fifo #(.DATA_WIDTH(32), .NUM_OUT(4), .DEPTH(4)) u4 (.clk(clk), .reset(reset), .io(io4), .drop_count(drop4));
  stream_router_fifo #(.DATA_WIDTH(32), .NUM_OUT(3), .DEPTH(4)) u3 (.clk(clk), .reset(reset), .io(io3), .drop_count(drop3));
  typedef struct {
    logic [31:0] din;
    logic v;
    logic [1:0] addr;
    logic b;
    logic [3:0] rdy;
    logic er;
    logic [3:0] ev;
    logic [127:0] ed;
  } vec_t;
  vec_t t[$];
  task automatic add(input logic [31:0] din, input logic v, input logic [1:0] addr, input logic b, input logic [3:0] rdy,
                     input logic er, input logic [3:0] ev, input logic [31:0] e3, e2, e1, e0);
    vec_t x;
    x.din = din; x.v = v; x.addr = addr; x.b = b; x.rdy = rdy;
    x.er = er; x.ev = ev; x.ed = {e3, e2, e1, e0};
    t.push_back(x);
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push4(input logic [1:0] a, input logic [31:0] d);
    io4.din = d; io4.addr = a; io4.bcast = 0; io4.din_valid = 1;
    step();
    io4.din_valid = 0;
  endtask
  initial begin
    // routing and back-pressure
    add(32'hA5A50001, 1, 2, 0, 4'b0000, 1, 4'b0100, 0, 32'hA5A50001, 0, 0);
    add(0, 0, 0, 0, 4'b0100, 1, 4'b0000, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(i, 1, 1, 0, 4'b0000, 1, 4'b0010, 0, 0, 1, 0);
    add(5, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 1, 0);
    add(9, 1, 0, 0, 4'b0000, 1, 4'b0011, 0, 0, 1, 9);
    add(0, 0, 0, 0, 4'b0011, 1, 4'b0010, 0, 0, 2, 0);
    add(0, 0, 0, 0, 4'b0010, 1, 4'b0010, 0, 0, 3, 0);
    add(0, 0, 0, 0, 4'b0010, 1, 4'b0010, 0, 0, 4, 0);
    add(0, 0, 0, 0, 4'b0010, 1, 4'b0000, 0, 0, 0, 0);
    // broadcast blocked by a full channel, then accepted atomically
    for (int i = 11; i <= 14; i++) add(i, 1, 3, 0, 4'b0000, 1, 4'b1000, 11, 0, 0, 0);
    add(32'hBEEF, 1, 0, 1, 4'b0000, 0, 4'b1000, 11, 0, 0, 0);
    add(32'hBEEF, 0, 0, 1, 4'b1000, 0, 4'b1000, 12, 0, 0, 0);
    add(32'hBEEF, 1, 0, 1, 4'b0000, 1, 4'b1111, 12, 32'hBEEF, 32'hBEEF, 32'hBEEF);
    add(0, 0, 0, 0, 4'b0111, 1, 4'b1000, 12, 0, 0, 0);
    add(0, 0, 0, 0, 4'b1000, 1, 4'b1000, 13, 0, 0, 0);
    add(0, 0, 0, 0, 4'b1000, 1, 4'b1000, 14, 0, 0, 0);
    add(0, 0, 0, 0, 4'b1000, 1, 4'b1000, 32'hBEEF, 0, 0, 0);
    add(0, 0, 0, 0, 4'b1000, 1, 4'b0000, 0, 0, 0, 0);
    // simultaneous push and pop keeps occupancy
    add(5, 1, 0, 0, 4'b0000, 1, 4'b0001, 0, 0, 0, 5);
    add(6, 1, 0, 0, 4'b0000, 1, 4'b0001, 0, 0, 0, 5);
    add(7, 1, 0, 0, 4'b0001, 1, 4'b0001, 0, 0, 0, 6);
    add(0, 0, 0, 0, 4'b0001, 1, 4'b0001, 0, 0, 0, 7);
    add(0, 0, 0, 0, 4'b0001, 1, 4'b0000, 0, 0, 0, 0);
    // full channel popping in the same cycle still refuses the push
    for (int i = 21; i <= 24; i++) add(i, 1, 2, 0, 4'b0000, 1, 4'b0100, 0, 21, 0, 0);
    add(25, 1, 2, 0, 4'b0100, 0, 4'b0100, 0, 22, 0, 0);
    add(25, 1, 2, 0, 4'b0000, 1, 4'b0100, 0, 22, 0, 0);
    io4.din = 0; io4.din_valid = 0; io4.addr = 0; io4.bcast = 0; io4.dout_ready = 0;
    io3.din = 0; io3.din_valid = 0; io3.addr = 0; io3.bcast = 0; io3.dout_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("reset_valid", io4.dout_valid, 0);
    chk("reset_dout", io4.dout, 0);
    chk("reset_drop", drop4, 0);
    chk("reset_ready", io4.din_ready, 1);
    step();
    foreach (t[k]) begin
      io4.din = t[k].din; io4.din_valid = t[k].v; io4.addr = t[k].addr;
      io4.bcast = t[k].b; io4.dout_ready = t[k].rdy;
      #1;
      chk($sformatf("v%0d_ready", k), io4.din_ready, t[k].er);
      step();
      chk($sformatf("v%0d_valid", k), io4.dout_valid, t[k].ev);
      chk($sformatf("v%0d_dout", k), io4.dout, t[k].ed);
    end
    io4.din_valid = 0; io4.bcast = 0; io4.dout_ready = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain2_%0d", i), io4.dout[64 +: 32], 22 + i);
      step();
    end
    io4.dout_ready = 0;
    chk("drain2_empty", io4.dout_valid, 0);
    chk("drop4_zero", drop4, 0);
    // out-of-range drops on the 3-channel instance
    io3.din = 32'hDEAD; io3.addr = 3; io3.din_valid = 1;
    #1;
    chk("drop_ready", io3.din_ready, 1);
    step(); step(); step();
    chk("drop_count3", drop3, 3);
    chk("drop_novalid", io3.dout_valid, 0);
    repeat (65534) step();
    chk("drop_sat", drop3, 16'hFFFF);
    step();
    chk("drop_sat_hold", drop3, 16'hFFFF);
    io3.din_valid = 0;
    // async reset between edges with channels holding 3,1,0,2 words
    for (int i = 0; i < 3; i++) push4(0, 32'h100 + i);
    push4(1, 32'h200);
    push4(3, 32'h300); push4(3, 32'h301);
    chk("pre_reset_valid", io4.dout_valid, 4'b1011);
    chk("pre_reset_dout", io4.dout, {32'h300, 32'h0, 32'h200, 32'h100});
    #3 reset = 1;
    #1;
    chk("async_valid", io4.dout_valid, 0);
    chk("async_dout", io4.dout, 0);
    chk("async_drop3", drop3, 0);
    @(posedge clk);
    #1 reset = 0;
    push4(0, 32'hC0DE);
    chk("post_reset_valid", io4.dout_valid, 4'b0001);
    chk("post_reset_dout", io4.dout, {96'h0, 32'hC0DE});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
